// File: rtl/cpu6502_alu_pkg.sv
// Shared opcode constants, FSM state encoding and strobe bundle for the
// 6502-style ALU sequencer.
package cpu6502_alu_pkg;

   localparam int OP_ADD = 0;
   localparam int OP_SUB = 1;
   localparam int OP_AND = 2;
   localparam int OP_EOR = 3;
   localparam int OP_ORA = 4;
   localparam int OP_LSR = 5;
   localparam int OP_INC = 6;
   localparam int OP_DEC = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // ALU control strobes; one_addc is the carry injected into the adder,
   // zero_add forces the A side of the adder to 0x00.
   typedef struct packed {
      logic sb_add;
      logic zero_add;
      logic db_add;
      logic db_n_add;
      logic adl_add;
      logic one_addc;
      logic sums;
      logic ands;
      logic eors;
      logic ors;
      logic srs;
   } strobe_t;

endpackage

// File: rtl/alu_strobe_decode.sv
// Combinational opcode -> ALU strobe mapping. All strobes are zero when
// enable is low or the opcode is illegal. adl_add is never used here.
module alu_strobe_decode
   import cpu6502_alu_pkg::*;
#(
   parameter int OP_W = 4
) (
   input  logic [OP_W-1:0] op,
   input  logic            carry,
   input  logic            enable,
   output strobe_t         strobes
);

   // Decode the strobe set for the latched opcode while the ALU is driven.
   always_comb begin
      strobes = '0;
      if (enable) begin
         case (int'(op))
            OP_ADD: begin
               strobes.sb_add   = 1'b1;
               strobes.db_add   = 1'b1;
               strobes.sums     = 1'b1;
               strobes.one_addc = carry;
            end
            OP_SUB: begin
               strobes.sb_add   = 1'b1;
               strobes.db_n_add = 1'b1;
               strobes.sums     = 1'b1;
               strobes.one_addc = carry;
            end
            OP_AND: begin
               strobes.sb_add = 1'b1;
               strobes.db_add = 1'b1;
               strobes.ands   = 1'b1;
            end
            OP_EOR: begin
               strobes.sb_add = 1'b1;
               strobes.db_add = 1'b1;
               strobes.eors   = 1'b1;
            end
            OP_ORA: begin
               strobes.sb_add = 1'b1;
               strobes.db_add = 1'b1;
               strobes.ors    = 1'b1;
            end
            OP_LSR: begin
               strobes.db_add = 1'b1;
               strobes.srs    = 1'b1;
            end
            OP_INC: begin
               strobes.zero_add = 1'b1;
               strobes.db_add   = 1'b1;
               strobes.sums     = 1'b1;
               strobes.one_addc = 1'b1;
            end
            OP_DEC: begin
               // A side left floating (0xFF) so the adder yields B - 1.
               strobes.db_add = 1'b1;
               strobes.sums   = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation: accept request, drive operand buses and
// strobes for two cycles, capture the ALU ADD output, present the result.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. o_op_ready is high only in IDLE; o_res_valid is high only in
// DONE and holds until i_res_ready is seen high on a rising edge.
module alu_sequencer
   import cpu6502_alu_pkg::*;
#(
   parameter int OP_W = 4
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_op_valid,
   output logic            o_op_ready,
   input  logic [OP_W-1:0] i_op,
   input  logic [7:0]      i_a,
   input  logic [7:0]      i_b,
   input  logic            i_carry,
   output logic [7:0]      o_sb,
   output logic [7:0]      o_db,
   output logic            o_sb_add,
   output logic            o_0_add,
   output logic            o_db_add,
   output logic            o_db_n_add,
   output logic            o_adl_add,
   output logic            o_1_addc,
   output logic            o_sums,
   output logic            o_ands,
   output logic            o_eors,
   output logic            o_ors,
   output logic            o_srs,
   input  logic [7:0]      i_add,
   output logic            o_res_valid,
   input  logic            i_res_ready,
   output logic [7:0]      o_result,
   output logic            o_n,
   output logic            o_z,
   output logic            o_err,
   output state_t          o_state
);

   state_t          state_q, state_d;
   logic [OP_W-1:0] op_q;
   logic [7:0]      a_q, b_q;
   logic            carry_q;
   logic            accept, drive, op_legal;
   logic [7:0]      cap_value;
   strobe_t         strobes;

   assign accept    = i_op_valid && o_op_ready;
   assign drive     = (state_q == ST_LOAD) || (state_q == ST_HOLD);
   assign op_legal  = (int'(op_q) <= OP_DEC);
   assign cap_value = op_legal ? i_add : 8'h00;

   // Ready is held low while reset is asserted, rising on release.
   assign o_op_ready  = (state_q == ST_IDLE) && i_reset_n;
   assign o_res_valid = (state_q == ST_DONE);
   assign o_state     = state_q;
   assign o_sb        = drive ? a_q : 8'h00;
   assign o_db        = drive ? b_q : 8'h00;

   alu_strobe_decode #(.OP_W(OP_W)) u_decode (
      .op      (op_q),
      .carry   (carry_q),
      .enable  (drive),
      .strobes (strobes)
   );

   assign o_sb_add   = strobes.sb_add;
   assign o_0_add    = strobes.zero_add;
   assign o_db_add   = strobes.db_add;
   assign o_db_n_add = strobes.db_n_add;
   assign o_adl_add  = strobes.adl_add;
   assign o_1_addc   = strobes.one_addc;
   assign o_sums     = strobes.sums;
   assign o_ands     = strobes.ands;
   assign o_eors     = strobes.eors;
   assign o_ors      = strobes.ors;
   assign o_srs      = strobes.srs;

   // State register; reset abandons any in-flight operation.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   // Next-state logic for the fixed four-step sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_HOLD;
         ST_HOLD: state_d = ST_DONE;
         ST_DONE: if (i_res_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Latch the request on acceptance; inputs are ignored at all other times.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         op_q    <= '0;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         carry_q <= 1'b0;
      end else if (accept) begin
         op_q    <= i_op;
         a_q     <= i_a;
         b_q     <= i_b;
         carry_q <= i_carry;
      end
   end

   // Capture the ALU output and its flags on the edge that ends HOLD.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_result <= 8'h00;
         o_n      <= 1'b0;
         o_z      <= 1'b0;
         o_err    <= 1'b0;
      end else if (state_q == ST_HOLD) begin
         o_result <= cap_value;
         o_n      <= cap_value[7];
         o_z      <= (cap_value == 8'h00);
         o_err    <= !op_legal;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU drives i_add from the buses
// and strobes; results are compared to a reference computed from opcode
// arithmetic.
module tb_alu_sequencer;
   import cpu6502_alu_pkg::*;

   localparam int OP_W = 4;

   logic            i_clk = 1'b0;
   logic            i_reset_n = 1'b0;
   logic            i_op_valid = 1'b0;
   logic            o_op_ready;
   logic [OP_W-1:0] i_op = '0;
   logic [7:0]      i_a = 8'h00, i_b = 8'h00;
   logic            i_carry = 1'b0;
   logic [7:0]      o_sb, o_db;
   logic            o_sb_add, o_0_add, o_db_add, o_db_n_add, o_adl_add, o_1_addc;
   logic            o_sums, o_ands, o_eors, o_ors, o_srs;
   logic [7:0]      i_add;
   logic            o_res_valid;
   logic            i_res_ready = 1'b0;
   logic [7:0]      o_result;
   logic            o_n, o_z, o_err;
   state_t          o_state;

   int checks = 0;
   int failures = 0;
   logic [8:0] exp_q[$];
   logic [10:0] strobe_vec;

   // ---------------- clock / reset ----------------
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   alu_sequencer #(.OP_W(OP_W)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_op_valid(i_op_valid), .o_op_ready(o_op_ready),
      .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_carry(i_carry),
      .o_sb(o_sb), .o_db(o_db),
      .o_sb_add(o_sb_add), .o_0_add(o_0_add), .o_db_add(o_db_add),
      .o_db_n_add(o_db_n_add), .o_adl_add(o_adl_add), .o_1_addc(o_1_addc),
      .o_sums(o_sums), .o_ands(o_ands), .o_eors(o_eors), .o_ors(o_ors), .o_srs(o_srs),
      .i_add(i_add),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
      .o_result(o_result), .o_n(o_n), .o_z(o_z), .o_err(o_err),
      .o_state(o_state)
   );

   assign strobe_vec = {o_sb_add, o_0_add, o_db_add, o_db_n_add, o_adl_add, o_1_addc,
                        o_sums, o_ands, o_eors, o_ors, o_srs};

   // Behavioural ALU: A side floats to 0xFF unless driven, output per function strobe.
   always_comb begin
      logic [7:0] aside, bside;
      aside = o_sb_add ? o_sb : (o_0_add ? 8'h00 : 8'hFF);
      bside = o_db_add ? o_db : (o_db_n_add ? ~o_db : 8'hFF);
      i_add = 8'hFF;
      if (o_sums)      i_add = aside + bside + {7'd0, o_1_addc};
      else if (o_ands) i_add = aside & bside;
      else if (o_eors) i_add = aside ^ bside;
      else if (o_ors)  i_add = aside | bside;
      else if (o_srs)  i_add = {1'b0, bside[7:1]};
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference result: {err, result} from the opcode's arithmetic meaning.
   function automatic logic [8:0] ref_alu(input int op, input int a, input int b, input int c);
      int r;
      r = 0;
      case (op)
         0: r = a + b + c;
         1: r = a - b - (1 - c);
         2: r = a & b;
         3: r = a ^ b;
         4: r = a | b;
         5: r = b / 2;
         6: r = b + 1;
         7: r = b - 1;
         default: return 9'h100;
      endcase
      return {1'b0, 8'(r)};
   endfunction

   // Expected strobe set {sb,0,db,db_n,adl,1c,sums,ands,eors,ors,srs} from the opcode table.
   function automatic logic [10:0] exp_strobes(input int op, input logic c);
      case (op)
         0: return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, c,    1'b1, 4'b0000};
         1: return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c,    1'b1, 4'b0000};
         2: return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000};
         3: return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100};
         4: return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010};
         5: return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001};
         6: return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};
         7: return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
         default: return 11'd0;
      endcase
   endfunction

   // Strobe exclusivity, sampled every cycle out of reset.
   always @(negedge i_clk) begin
      if (i_reset_n) begin
         check("inv_adl_never", o_adl_add, 0);
         check("inv_fn_onehot", ($countones({o_sums, o_ands, o_eors, o_ors, o_srs}) <= 1), 1);
         check("inv_db_onehot", ($countones({o_db_add, o_db_n_add, o_adl_add}) <= 1), 1);
         check("inv_a_onehot", ($countones({o_0_add, o_sb_add}) <= 1), 1);
      end
   end

   // ---------------- driver ----------------
   task automatic run_op(input int op, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input int delay, input bit reset_in_hold);
      int waitc;
      logic [8:0] exp;
      logic [10:0] es;
      logic [7:0] add_seen;
      waitc = 0;
      while (!o_op_ready && waitc < 20) begin
         @(negedge i_clk);
         waitc++;
      end
      check("accept_ready", o_op_ready, 1);
      i_op = OP_W'(op); i_a = a; i_b = b; i_carry = c; i_op_valid = 1'b1;
      @(posedge i_clk); #1;
      // Post-acceptance input changes must be ignored.
      i_op_valid = 1'b0;
      i_op = OP_W'($urandom); i_a = 8'($urandom); i_b = 8'($urandom); i_carry = 1'($urandom);
      es = exp_strobes(op, c);
      check("load_valid", o_res_valid, 0);
      check("load_ready", o_op_ready, 0);
      check("load_sb", o_sb, a);
      check("load_db", o_db, b);
      check("load_strobes", strobe_vec, es);
      @(posedge i_clk); #1;
      check("hold_valid", o_res_valid, 0);
      check("hold_sb", o_sb, a);
      check("hold_db", o_db, b);
      check("hold_strobes", strobe_vec, es);
      add_seen = i_add;
      if (reset_in_hold) begin
         i_reset_n = 1'b0;
         #1;
         check("rst_state", o_state, ST_IDLE);
         check("rst_strobes", strobe_vec, 0);
         check("rst_buses", {o_sb, o_db}, 0);
         check("rst_valid", o_res_valid, 0);
         check("rst_ready", o_op_ready, 0);
         check("rst_flags", {o_result, o_n, o_z, o_err}, 0);
         @(negedge i_clk);
         i_reset_n = 1'b1;
         repeat (6) begin
            @(negedge i_clk);
            check("rst_no_valid", o_res_valid, 0);
         end
         check("rst_ready_back", o_op_ready, 1);
         return;
      end
      exp_q.push_back(ref_alu(op, a, b, c));
      @(posedge i_clk); #1;
      check("latency_valid", o_res_valid, 1);
      if (exp_q.size() == 0) begin
         check("sb_empty", 0, 1);
         return;
      end
      exp = exp_q.pop_front();
      check("res_value", o_result, exp[7:0]);
      check("res_n", o_n, exp[7]);
      check("res_z", o_z, (exp[7:0] == 8'h00));
      check("res_err", o_err, exp[8]);
      if (op <= 7) check("res_vs_alu", o_result, add_seen);
      check("done_buses", {o_sb, o_db}, 0);
      check("done_strobes", strobe_vec, 0);
      repeat (delay) begin
         @(posedge i_clk); #1;
         check("stall_valid", o_res_valid, 1);
         check("stall_result", o_result, exp[7:0]);
         check("stall_ready", o_op_ready, 0);
      end
      i_res_ready = 1'b1;
      @(posedge i_clk); #1;
      i_res_ready = 1'b0;
      check("after_valid", o_res_valid, 0);
      check("after_ready", o_op_ready, 1);
      check("after_hold", {o_result, o_err}, {exp[7:0], exp[8]});
   endtask

   // ---------------- sequence ----------------
   initial begin
      @(negedge i_clk);
      check("reset_valid", o_res_valid, 0);
      check("reset_ready", o_op_ready, 0);
      check("reset_outs", {o_result, o_n, o_z, o_err, o_sb, o_db}, 0);
      check("reset_strobes", strobe_vec, 0);
      check("reset_state", o_state, ST_IDLE);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      @(negedge i_clk);
      check("release_ready", o_op_ready, 1);

      run_op(OP_ADD, 8'h7F, 8'h01, 1'b0, 0, 1'b0);
      run_op(OP_SUB, 8'h05, 8'h05, 1'b1, 0, 1'b0);
      run_op(OP_SUB, 8'h05, 8'h05, 1'b0, 1, 1'b0);
      run_op(OP_DEC, 8'h33, 8'h00, 1'b0, 0, 1'b0);
      run_op(OP_INC, 8'h33, 8'hFF, 1'b0, 0, 1'b0);
      run_op(10,     8'h12, 8'h34, 1'b1, 0, 1'b0);
      run_op(OP_LSR, 8'h00, 8'h81, 1'b1, 0, 1'b0);
      run_op(OP_ADD, 8'hC3, 8'h5A, 1'b1, 5, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_op(int'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                1'($urandom), int'($urandom_range(0, 3)), 1'b0);
      end

      run_op(OP_ADD, 8'h10, 8'h20, 1'b0, 0, 1'b1);
      run_op(OP_EOR, 8'hF0, 8'hFF, 1'b0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter OP_W, default 4, opcode width.
REQ-002 SHALL have port i_clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_op_valid / o_op_ready  input/output  1/1  request handshake.
REQ-005 SHALL have port i_op  input  OP_W  opcode: 0 ADD, 1 SUB, 2 AND, 3 EOR, 4 ORA, 5 LSR, 6 INC, 7 DEC, 8-15 illegal.
REQ-006 SHALL have ports i_a, i_b  input  8 each  operands; i_carry  input  1  carry in.
REQ-007 SHALL have ports o_sb, o_db  output  8 each  operand buses driven to the ALU.
REQ-008 SHALL have ports o_sb_add, o_0_add, o_db_add, o_db_n_add, o_adl_add, o_1_addc, o_sums, o_ands, o_eors, o_ors, o_srs  output  1 each  ALU control strobes.
REQ-009 SHALL have port i_add  input  8  ALU ADD output.
REQ-010 SHALL have ports o_res_valid / i_res_ready  output/input  1/1  result handshake.
REQ-011 SHALL have ports o_result 8, o_n 1, o_z 1, o_err 1  outputs  result, negative, zero, illegal-op flag.

Function
REQ-012 SHALL implement FSM IDLE -> LOAD -> HOLD -> DONE -> IDLE.
REQ-013 SHALL assert o_op_ready only in IDLE; request accepted when i_op_valid & o_op_ready at a rising edge.
REQ-014 SHALL on acceptance latch i_op, i_a, i_b, i_carry and enter LOAD.
REQ-015 SHALL drive o_sb = latched A and o_db = latched B in LOAD and HOLD; 0x00 otherwise.
REQ-016 SHALL assert strobes only in LOAD and HOLD, identical in both, per opcode:
- ADD: sb_add, db_add, sums, 1_addc = carry.
- SUB: sb_add, db_n_add, sums, 1_addc = carry.
- AND/EOR/ORA: sb_add, db_add, ands/eors/ors.
- LSR: db_add, srs.
- INC: 0_add, db_add, sums, 1_addc = 1.
- DEC: db_add, sums only; A side floats to 0xFF, giving B-1.
- illegal: no strobes.
REQ-017 SHALL never assert o_adl_add; SHALL assert at most one of sums/ands/eors/ors/srs, at most one of db_add/db_n_add/adl_add, at most one of 0_add/sb_add.
REQ-018 SHALL in HOLD sample i_add at the rising edge ending HOLD into o_result and enter DONE; illegal ops capture 0x00.
REQ-019 SHALL compute o_n = result[7], o_z = (result == 0) from the captured value, registered with it.
REQ-020 SHALL assert o_err with o_res_valid for illegal opcodes, cleared on the next capture.
REQ-021 SHALL assert o_res_valid only in DONE; leave DONE when i_res_ready is high at a rising edge.
REQ-022 SHALL hold o_result/o_n/o_z/o_err stable from capture until the next capture.
REQ-023 SHALL give latency of 3 rising edges from acceptance to o_res_valid high; minimum request interval 4 cycles.
REQ-024 SHALL ignore i_op_valid and operand changes outside IDLE.
REQ-025 SHALL wrap arithmetic modulo 256; carry-out is not produced.

Reset
REQ-026 SHALL on i_reset_n low asynchronously force IDLE and zero all outputs except o_op_ready, which goes high on release.
REQ-027 SHALL abandon any in-flight operation on reset with no result delivered.

Structure
REQ-028 SHALL place opcode constants and the FSM state enumeration in a shared package cpu6502_alu_pkg.
REQ-029 SHALL contain one sub-module, alu_strobe_decode, combinationally mapping opcode to the strobe set.

Verification
REQ-030 SHALL verify ADD A=0x7F, B=0x01, carry=0 -> result 0x80, n=1, z=0, valid on 3rd edge after acceptance.
REQ-031 SHALL verify SUB A=0x05, B=0x05 -> db_n_add and sums high in LOAD/HOLD, o_1_addc=carry, result equals sampled i_add.
REQ-032 SHALL verify DEC B=0x00 -> result 0xFF, n=1; INC B=0xFF -> result 0x00, z=1.
REQ-033 SHALL verify opcode 0xA -> no strobes, result 0x00, o_err=1, z=1.
REQ-034 SHALL verify i_res_ready held low 5 cycles -> o_res_valid and o_result stable, o_op_ready low throughout.
REQ-035 SHALL verify reset asserted in HOLD -> IDLE immediately, all strobes 0, no o_res_valid after release.
